// File: rtl/clock_edge_monitor.sv
`default_nettype none
// ============================================================================
// Module   : clock_edge_monitor
// Purpose  : Samples a slow, asynchronous divided clock in the fast clk_in
//            domain. Turns its accepted edges into one-cycle rise/fall ticks,
//            measures period and high time in clk_in cycles, counts rising
//            edges and flags loss of the monitored clock.
// Options  : GLITCH_FILTER_EN - when defined, the synchronized level must stay
//            constant for FILTER_LEN consecutive cycles before it is accepted.
//            When undefined, the last synchronizer stage is the accepted level.
// Ports    : clk_in       in   fast system clock
//            reset_n      in   asynchronous active-low reset
//            slow_clk     in   asynchronous clock being monitored
//            clear        in   synchronous clear of measurements and state
//            rise_tick    out  one-cycle pulse per accepted rising edge
//            fall_tick    out  one-cycle pulse per accepted falling edge
//            period       out  clk_in cycles between the last two rise ticks
//            high_time    out  clk_in cycles from a rise tick to the next fall
//            period_valid out  period holds a real measurement
//            clk_lost     out  no rising edge for TIMEOUT cycles
//            edge_count   out  rise tick count, wraps at 16 bits
// Revision : 1.0 - initial release
// ============================================================================
module clock_edge_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 27,
  parameter int TIMEOUT     = 100000000,
  parameter int FILTER_LEN  = 4
) (
  input  logic                 clk_in,
  input  logic                 reset_n,
  input  logic                 slow_clk,
  input  logic                 clear,
  output logic                 rise_tick,
  output logic                 fall_tick,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 period_valid,
  output logic                 clk_lost,
  output logic [15:0]          edge_count
);

  localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_LOCKED = 2'd2,
    ST_LOST   = 2'd3
  } state_t;

  // Reject configurations the synchronizer or the filter cannot support.
  generate
    if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_param_check
      $error("clock_edge_monitor: SYNC_STAGES must be >= 2 and FILTER_LEN >= 1");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Synchronizer: slow_clk enters at bit 0, the top bit is the safe level.
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync_lvl;
  logic                   w_acc_lvl;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], slow_clk};
    end
  end

  assign w_sync_lvl = r_sync[SYNC_STAGES-1];

`ifdef GLITCH_FILTER_EN
  // --------------------------------------------------------------------------
  // Glitch filter: r_stable counts consecutive cycles in which the
  // synchronized level disagrees with the accepted level. Once the
  // disagreement has lasted FILTER_LEN cycles the new level is taken.
  // A shorter excursion resets the count and leaves no trace.
  // --------------------------------------------------------------------------
  localparam int              c_FW        = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [c_FW-1:0] c_FILT_LAST = c_FW'(FILTER_LEN - 1);
  localparam logic [c_FW-1:0] c_FILT_ONE  = c_FW'(1);

  logic [c_FW-1:0] r_stable;
  logic            r_acc;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_stable <= '0;
      r_acc    <= 1'b0;
    end else if (w_sync_lvl == r_acc) begin
      r_stable <= '0;
    end else if (r_stable == c_FILT_LAST) begin
      r_acc    <= w_sync_lvl;
      r_stable <= '0;
    end else begin
      r_stable <= r_stable + c_FILT_ONE;
    end
  end

  assign w_acc_lvl = r_acc;
`else
  assign w_acc_lvl = w_sync_lvl;
`endif

  // --------------------------------------------------------------------------
  // Edge detection against the previously accepted level. Only one level is
  // accepted per cycle, so rise and fall are mutually exclusive.
  // --------------------------------------------------------------------------
  logic r_level;
  logic w_rise;
  logic w_fall;

  assign w_rise = w_acc_lvl & ~r_level;
  assign w_fall = ~w_acc_lvl & r_level;

  // --------------------------------------------------------------------------
  // Cycle counter, measurements and lock state.
  // --------------------------------------------------------------------------
  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 w_cnt_sat;
  logic                 w_timeout;
  logic                 w_measuring;

  assign w_cnt_sat   = (r_cnt == c_CNT_MAX);
  // Widened compare: a TIMEOUT beyond the counter range can never be reached,
  // because the counter saturates instead of wrapping.
  assign w_timeout   = (64'(r_cnt) >= 64'(TIMEOUT));
  // High time is only meaningful once a rise tick has anchored the counter
  // and the monitored clock has not been declared lost.
  assign w_measuring = (r_state == ST_ARMED) || (r_state == ST_LOCKED);

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_level      <= 1'b0;
      r_cnt        <= '0;
      rise_tick    <= 1'b0;
      fall_tick    <= 1'b0;
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
      clk_lost     <= 1'b0;
      edge_count   <= '0;
    end else begin
      // The previous level keeps following the accepted level even during
      // clear, so an edge discarded by clear is not re-detected afterwards.
      r_level <= w_acc_lvl;

      if (clear) begin
        r_state      <= ST_IDLE;
        r_cnt        <= '0;
        rise_tick    <= 1'b0;
        fall_tick    <= 1'b0;
        period       <= '0;
        high_time    <= '0;
        period_valid <= 1'b0;
        clk_lost     <= 1'b0;
        edge_count   <= '0;
      end else begin
        rise_tick <= w_rise;
        fall_tick <= w_fall;

        if (w_rise) begin
          r_cnt      <= c_CNT_ONE;
          edge_count <= edge_count + 16'd1;
        end else if (!w_cnt_sat) begin
          r_cnt <= r_cnt + c_CNT_ONE;
        end

        if (w_fall && w_measuring) begin
          high_time <= r_cnt;
        end

        case (r_state)
          ST_IDLE: begin
            // No timeout here: loss is only meaningful after a first edge.
            if (w_rise) begin
              r_state <= ST_ARMED;
            end
          end
          ST_ARMED: begin
            if (w_rise) begin
              r_state      <= ST_LOCKED;
              period       <= r_cnt;
              period_valid <= 1'b1;
            end else if (w_timeout) begin
              r_state      <= ST_LOST;
              clk_lost     <= 1'b1;
              period_valid <= 1'b0;
            end
          end
          ST_LOCKED: begin
            if (w_rise) begin
              period <= r_cnt;
            end else if (w_timeout) begin
              r_state      <= ST_LOST;
              clk_lost     <= 1'b1;
              period_valid <= 1'b0;
            end
          end
          ST_LOST: begin
            // Period and high time keep their last values; a returning
            // clock must show two rises again before period is trusted.
            if (w_rise) begin
              r_state  <= ST_ARMED;
              clk_lost <= 1'b0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clock_edge_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_edge_monitor
// Purpose  : Self-checking bench for clock_edge_monitor. Two instances share
//            slow_clk/clear: dut_a (8-bit counters, TIMEOUT 64) and dut_b
//            (4-bit counters, unreachable TIMEOUT) for saturation. A
//            timestamp-based reference model predicts every output each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_edge_monitor;

  localparam int SS = 2;
  localparam int FL = 4;
`ifdef GLITCH_FILTER_EN
  localparam int LAT  = SS + 1 + FL;
  localparam int GLIT = 0;
`else
  localparam int LAT  = SS + 1;
  localparam int GLIT = 1;
`endif

  logic clk_in   = 1'b0;
  logic reset_n  = 1'b0;
  logic slow_clk = 1'b0;
  logic clear    = 1'b0;

  logic       rt_a, ft_a, pv_a, cl_a;
  logic [7:0] per_a, ht_a;
  logic [15:0] ec_a;
  logic       rt_b, ft_b, pv_b, cl_b;
  logic [3:0] per_b, ht_b;
  logic [15:0] ec_b;

  clock_edge_monitor #(.SYNC_STAGES(SS), .CNT_WIDTH(8), .TIMEOUT(64), .FILTER_LEN(FL)) dut_a (
    .clk_in(clk_in), .reset_n(reset_n), .slow_clk(slow_clk), .clear(clear),
    .rise_tick(rt_a), .fall_tick(ft_a), .period(per_a), .high_time(ht_a),
    .period_valid(pv_a), .clk_lost(cl_a), .edge_count(ec_a)
  );

  clock_edge_monitor #(.SYNC_STAGES(SS), .CNT_WIDTH(4), .TIMEOUT(1000), .FILTER_LEN(FL)) dut_b (
    .clk_in(clk_in), .reset_n(reset_n), .slow_clk(slow_clk), .clear(clear),
    .rise_tick(rt_b), .fall_tick(ft_b), .period(per_b), .high_time(ht_b),
    .period_valid(pv_b), .clk_lost(cl_b), .edge_count(ec_b)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;
  int n_rise_obs = 0;
  int n_fall_obs = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model. History of sampled slow_clk values and accepted levels
  // is kept per cycle; counters are expressed as "cycles since an anchor".
  // --------------------------------------------------------------------------
  typedef enum {M_IDLE, M_ARMED, M_LOCKED, M_LOST} mst_e;

  int   m_max [2] = '{255, 15};
  int   m_to  [2] = '{64, 1000};
  bit   s_q[$];
  bit   a_q[$];
  int   cyc;
  mst_e m_st   [2];
  int   m_base [2];
  int   m_per  [2];
  int   m_high [2];
  int   m_ec   [2];
  bit   m_valid[2];
  bit   m_lost [2];
  bit   e_rt, e_ft;
  bit   a_new, mrise, mfall, run_ok;
  int   cntp;

  function automatic bit s_at(int k);
    return (k < 1) ? 1'b0 : s_q[k-1];
  endfunction

  function automatic bit sl_at(int k);
    return s_at(k - SS + 1);
  endfunction

  function automatic bit a_at(int k);
    return (k < 1) ? 1'b0 : a_q[k-1];
  endfunction

  always @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      cyc = 0;
      s_q.delete();
      a_q.delete();
      e_rt = 1'b0;
      e_ft = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_st[i] = M_IDLE; m_base[i] = 0; m_per[i] = 0; m_high[i] = 0;
        m_ec[i] = 0; m_valid[i] = 1'b0; m_lost[i] = 1'b0;
      end
    end else begin
      cyc++;
      s_q.push_back(slow_clk);
`ifdef GLITCH_FILTER_EN
      run_ok = 1'b1;
      for (int j = 1; j <= FL; j++) begin
        if (sl_at(cyc - j) == a_at(cyc - 1)) run_ok = 1'b0;
      end
      a_new = run_ok ? !a_at(cyc - 1) : a_at(cyc - 1);
`else
      a_new = sl_at(cyc);
`endif
      a_q.push_back(a_new);
      mrise = a_at(cyc - 1) && !a_at(cyc - 2);
      mfall = !a_at(cyc - 1) && a_at(cyc - 2);
      e_rt  = mrise && !clear;
      e_ft  = mfall && !clear;
      for (int i = 0; i < 2; i++) begin
        cntp = cyc - 1 - m_base[i];
        if (cntp > m_max[i]) cntp = m_max[i];
        if (clear) begin
          m_st[i] = M_IDLE; m_base[i] = cyc; m_per[i] = 0; m_high[i] = 0;
          m_ec[i] = 0; m_valid[i] = 1'b0; m_lost[i] = 1'b0;
        end else begin
          if (mfall && (m_st[i] == M_ARMED || m_st[i] == M_LOCKED)) m_high[i] = cntp;
          if (mrise) begin
            m_ec[i]   = (m_ec[i] + 1) % 65536;
            m_base[i] = cyc - 1;
            case (m_st[i])
              M_IDLE:   m_st[i] = M_ARMED;
              M_ARMED:  begin m_st[i] = M_LOCKED; m_per[i] = cntp; m_valid[i] = 1'b1; end
              M_LOCKED: m_per[i] = cntp;
              default:  begin m_st[i] = M_ARMED; m_lost[i] = 1'b0; end
            endcase
          end else if ((m_st[i] == M_ARMED || m_st[i] == M_LOCKED) && cntp >= m_to[i]) begin
            m_st[i] = M_LOST; m_lost[i] = 1'b1; m_valid[i] = 1'b0;
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk_in) begin
    if (reset_n && mon_en) begin
      check_eq("dut_a_outputs",
               64'({rt_a, ft_a, pv_a, cl_a, ec_a, per_a, ht_a}),
               64'({e_rt, e_ft, m_valid[0], m_lost[0], 16'(m_ec[0]), 8'(m_per[0]), 8'(m_high[0])}));
      check_eq("dut_b_outputs",
               64'({rt_b, ft_b, pv_b, cl_b, ec_b, per_b, ht_b}),
               64'({e_rt, e_ft, m_valid[1], m_lost[1], 16'(m_ec[1]), 4'(m_per[1]), 4'(m_high[1])}));
      if (rt_a) n_rise_obs++;
      if (ft_a) n_fall_obs++;
    end
  end

  task automatic hold(input bit lvl, input int n, input bit clr_en);
    slow_clk = lvl;
    for (int i = 0; i < n; i++) begin
      clear = clr_en && ($urandom_range(0, 149) == 0);
      @(negedge clk_in);
    end
    clear = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    slow_clk = 1'b0;
    clear = 1'b0;
    repeat (3) @(negedge clk_in);
    reset_n = 1'b1;
  endtask

  initial begin
    #600000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  int k;

  initial begin
    // Reset state
    reset_n = 1'b0;
    repeat (3) @(negedge clk_in);
    check_eq("reset_a", 64'({rt_a, ft_a, pv_a, cl_a, ec_a, per_a, ht_a}), 64'd0);
    check_eq("reset_b", 64'({rt_b, ft_b, pv_b, cl_b, ec_b, per_b, ht_b}), 64'd0);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // 20-cycle period, 50% duty
    hold(1'b0, 5, 1'b0);
    repeat (4) begin
      hold(1'b1, 10, 1'b0);
      hold(1'b0, 10, 1'b0);
    end
    check_eq("period_20", 64'(per_a), 64'd20);
    check_eq("high_10", 64'(ht_a), 64'd10);
    check_eq("valid_locked", 64'(pv_a), 64'd1);
    check_eq("edge_count_4", 64'(ec_a), 64'd4);
    check_eq("period_saturated", 64'(per_b), 64'd15);
    check_eq("high_narrow_10", 64'(ht_b), 64'd10);
    check_eq("edge_count_b_4", 64'(ec_b), 64'd4);

    // Timeout: clk_lost 64 cycles after the last rise tick
    slow_clk = 1'b1;
    k = 0;
    while (!rt_a && k < 40) begin @(negedge clk_in); k++; end
    check_eq("rise_seen", 64'(rt_a), 64'd1);
    k = 0;
    while (!cl_a && k < 200) begin
      @(negedge clk_in);
      k++;
      if (k == 10) slow_clk = 1'b0;
    end
    check_eq("timeout_cycles", 64'(k), 64'd64);
    check_eq("lost_valid", 64'(pv_a), 64'd0);
    check_eq("lost_period_hold", 64'(per_a), 64'd20);
    check_eq("narrow_no_timeout", 64'(cl_b), 64'd0);
    hold(1'b1, 10, 1'b0);
    hold(1'b0, 10, 1'b0);
    check_eq("rearmed_valid", 64'(pv_a), 64'd0);
    check_eq("rearmed_lost", 64'(cl_a), 64'd0);
    hold(1'b1, 10, 1'b0);
    hold(1'b0, 10, 1'b0);
    check_eq("relocked_valid", 64'(pv_a), 64'd1);
    check_eq("relocked_period", 64'(per_a), 64'd20);

    // clear in the same cycle as a rise tick
    do_reset();
    hold(1'b0, 10, 1'b0);
    slow_clk = 1'b1;
    repeat (LAT - 1) @(negedge clk_in);
    clear = 1'b1;
    @(negedge clk_in);
    clear = 1'b0;
    check_eq("clr_rise_tick", 64'(rt_a), 64'd0);
    check_eq("clr_edge_count", 64'(ec_a), 64'd0);
    check_eq("clr_period", 64'(per_a), 64'd0);
    hold(1'b1, 9, 1'b0);
    hold(1'b0, 10, 1'b0);
    hold(1'b1, 10, 1'b0);
    hold(1'b0, 10, 1'b0);
    check_eq("clr_then_one_rise", 64'(ec_a), 64'd1);
    check_eq("clr_then_armed", 64'(pv_a), 64'd0);

    // 2-cycle glitch
    hold(1'b0, 20, 1'b0);
    n_rise_obs = 0;
    n_fall_obs = 0;
    hold(1'b1, 2, 1'b0);
    hold(1'b0, 20, 1'b0);
    check_eq("glitch_rise_count", 64'(n_rise_obs), 64'(GLIT));
    check_eq("glitch_fall_count", 64'(n_fall_obs), 64'(GLIT));

    // Randomized segments, glitches, stalls and clears
    for (int s = 0; s < 250; s++) begin
      int r;
      int len;
      r = $urandom_range(0, 9);
      if (r == 0)      len = $urandom_range(70, 100);
      else if (r < 3)  len = $urandom_range(1, 3);
      else             len = $urandom_range(4, 40);
      hold(~slow_clk, len, 1'b1);
    end

    // Asynchronous reset between clock edges
    hold(1'b1, 10, 1'b0);
    hold(1'b0, 10, 1'b0);
    hold(1'b1, 10, 1'b0);
    hold(1'b0, 10, 1'b0);
    @(posedge clk_in);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_reset_a", 64'({rt_a, ft_a, pv_a, cl_a, ec_a, per_a, ht_a}), 64'd0);
    check_eq("async_reset_b", 64'({rt_b, ft_b, pv_b, cl_b, ec_b, per_b, ht_b}), 64'd0);
    slow_clk = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    reset_n = 1'b1;
    hold(1'b0, 5, 1'b0);
    hold(1'b1, 10, 1'b0);
    hold(1'b0, 10, 1'b0);
    check_eq("post_reset_edge_count", 64'(ec_a), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
